dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32; width of the data bus.
REQ-002 Parameter ADDRESS_WIDTH, default 32; width of the byte address.
REQ-003 Parameter MAX_BURST, default 8; maximum consecutive locked grants to port 1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 p0_valid/p1_valid  in  1 each  request present (p0 = core load/store, p1 = loader/debug).
REQ-007 p0_ready/p1_ready  out  1 each  request accepted this cycle.
REQ-008 p0_we/p1_we  in  1 each  1 = write, 0 = read.
REQ-009 p0_addr/p1_addr  in  ADDRESS_WIDTH each  byte address.
REQ-010 p0_wdata/p1_wdata  in  DATA_WIDTH each  write data.
REQ-011 p1_lock  in  1  port 1 requests burst priority.
REQ-012 p0_rsp_valid/p1_rsp_valid  out  1 each  read data valid.
REQ-013 p0_rsp_rdata/p1_rsp_rdata  out  DATA_WIDTH each  read data.
REQ-014 mem_wr_en  out  1  data-memory write enable.
REQ-015 mem_addr  out  ADDRESS_WIDTH  data-memory address.
REQ-016 mem_wd  out  DATA_WIDTH  data-memory write data.
REQ-017 mem_rd  in  DATA_WIDTH  data-memory combinational read data.
REQ-018 conflict_cnt  out  16  saturating count of cycles in which a valid request was denied.

Function
REQ-019 At most one of p0_ready/p1_ready SHALL be high in any cycle; a transfer occurs when valid and ready are both high.
REQ-020 With a single valid port, that port SHALL be granted in the same cycle, with ready combinational from valid.
REQ-021 With both ports valid and no lock, the port not granted most recently SHALL win (round-robin, last_grant register).
REQ-022 Lock: if p1_lock=1, p1_valid=1 and the previous grant went to p1, p1 SHALL win while burst_cnt < MAX_BURST.
REQ-023 burst_cnt SHALL increment on each locked consecutive p1 grant.
REQ-024 burst_cnt SHALL clear on any p0 grant or when p1_lock=0.
REQ-025 At burst_cnt = MAX_BURST with p0_valid=1, p0 SHALL be granted and burst_cnt SHALL clear.
REQ-026 At burst_cnt = MAX_BURST with p0_valid=0, p1 SHALL continue to be granted and burst_cnt SHALL saturate.
REQ-027 mem_addr, mem_wd and mem_wr_en SHALL follow the granted port combinationally; mem_wr_en = granted we, and 0 with no grant.
REQ-028 With no grant, mem_addr and mem_wd SHALL hold 0.
REQ-029 A write SHALL complete at the accepting edge and produce no response.
REQ-030 An accepted read SHALL capture mem_rd at the accepting edge.
REQ-031 After an accepted read, the requester's rsp_valid SHALL be high for exactly the next cycle, with rsp_rdata = the captured data (latency 1).
REQ-032 rsp_rdata SHALL hold its last value when rsp_valid=0.
REQ-033 Back-to-back reads SHALL yield back-to-back rsp_valid pulses; no response is ever dropped or reordered.
REQ-034 conflict_cnt SHALL increment by 1 on each cycle with p0_valid & p1_valid (exactly one is denied) and saturate at 16'hFFFF.
REQ-035 last_grant SHALL update only on a transfer; idle cycles SHALL not change arbitration state.
REQ-036 Simultaneous write and read to the same address by different ports is impossible (single grant); the later-granted read SHALL see the earlier write.

Reset
REQ-037 While rst=1: last_grant=1 (p0 wins first contention), burst_cnt=0, both rsp_valid=0, both rsp_rdata=0, conflict_cnt=0.
REQ-038 Reset asserted mid-operation SHALL discard any pending read response; no rsp_valid SHALL follow the deassertion of reset.
REQ-039 Combinational grant outputs SHALL still follow valid during reset, and mem_wr_en SHALL be forced to 0 while rst=1.

Structure
REQ-040 Package dmem_arb_pkg SHALL hold the port-index constants (PORT_CORE=0, PORT_LOADER=1) and the default MAX_BURST.
REQ-041 Sub-module arb_rr2 SHALL implement the two-way round-robin/lock grant logic, with the lock and burst counter inside it.
REQ-042 Response registers, the data-path muxing and conflict_cnt SHALL reside in dmem_arbiter.

Verification
REQ-043 p0 write 0x100=0xDEADBEEF then p0 read 0x100 -> p0_ready on both requests; p0_rsp_valid one cycle after the read with rdata 0xDEADBEEF.
REQ-044 Both valid for 4 cycles after reset -> grants p0,p1,p0,p1; conflict_cnt=4.
REQ-045 p1_lock=1, both valid continuously, MAX_BURST=8 -> after p1 first wins, 8 consecutive p1 grants, then one p0 grant, then p1 resumes.
REQ-046 p0 read accepted, rst asserted the next cycle -> p0_rsp_valid=0 and rsp_rdata=0 during reset; no pulse after release.
REQ-047 Hold p0_valid & p1_valid for 70000 cycles -> conflict_cnt saturates at 0xFFFF.
REQ-048 Alternating p0/p1 reads, one per cycle, to distinct addresses -> each rsp_valid pulse goes only to the requesting port, in order, with correct data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared constants for the data-memory arbiter: port indices, the default
// lock burst length and the conflict counter ceiling, plus a saturating
// increment helper used by the conflict statistics.
package dmem_arb_pkg;

    // Port indices as 1-bit values so they compare directly against last_grant.
    localparam logic PORT_CORE   = 1'b0;   // p0: core load/store
    localparam logic PORT_LOADER = 1'b1;   // p1: loader/debug

    localparam int unsigned DEFAULT_MAX_BURST = 8;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    // Increment a 16-bit counter, sticking at CONFLICT_MAX.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == CONFLICT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
// Two-way round-robin arbiter with a burst lock for the loader port.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   req0, req1    request lines (core, loader)
//   lock          loader asks to keep the grant across consecutive cycles
//   gnt0, gnt1    one-hot (or zero) combinational grants
// The grant is combinational from the requests; a grant is always a transfer
// because a port is only granted while it requests.
module arb_rr2
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic lock,
    output logic gnt0,
    output logic gnt1
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

    logic          last_grant_q;
    logic          last_grant_d;
    logic [BW-1:0] burst_cnt_q;
    logic [BW-1:0] burst_cnt_d;
    logic          burst_open;

    // Grant selection: lock first, then round-robin on contention.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        burst_open = (burst_cnt_q < BURST_LIMIT);
        if (req0 && req1) begin
            if (lock && (last_grant_q == PORT_LOADER) && burst_open) begin
                gnt1 = 1'b1;
            end else if (last_grant_q == PORT_LOADER) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Next arbitration state; idle cycles leave last_grant untouched.
    always_comb begin
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if (gnt0) begin
            last_grant_d = PORT_CORE;
        end else if (gnt1) begin
            last_grant_d = PORT_LOADER;
        end else begin
            last_grant_d = last_grant_q;
        end

        // Only a p1 grant following a p1 grant extends the burst; the first
        // p1 grant after a p0 grant starts from the cleared count.
        if (!lock || gnt0) begin
            burst_cnt_d = '0;
        end else if (gnt1 && (last_grant_q == PORT_LOADER) && burst_open) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

    // Arbitration state registers; reset makes p0 win the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PORT_LOADER;
            burst_cnt_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-cycle data memory between the core (p0) and the
// loader/debug port (p1).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   pN_valid/pN_ready           request handshake, ready combinational
//   pN_we/pN_addr/pN_wdata      request attributes
//   p1_lock                     loader burst priority request
//   pN_rsp_valid/pN_rsp_rdata   one-cycle read response, data held afterwards
//   mem_wr_en/mem_addr/mem_wd   memory request, follows the granted port
//   mem_rd                      combinational memory read data
//   conflict_cnt                saturating count of contended cycles
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned MAX_BURST     = DEFAULT_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic                     p0_we,
    input  logic [ADDRESS_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]    p0_wdata,
    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic                     p1_we,
    input  logic [ADDRESS_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]    p1_wdata,
    input  logic                     p1_lock,
    output logic                     p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]    p0_rsp_rdata,
    output logic                     p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]    p1_rsp_rdata,
    output logic                     mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    output logic [15:0]              conflict_cnt
);

    logic                  gnt0;
    logic                  gnt1;
    logic                  p0_rsp_valid_q;
    logic                  p0_rsp_valid_d;
    logic [DATA_WIDTH-1:0] p0_rsp_rdata_q;
    logic [DATA_WIDTH-1:0] p0_rsp_rdata_d;
    logic                  p1_rsp_valid_q;
    logic                  p1_rsp_valid_d;
    logic [DATA_WIDTH-1:0] p1_rsp_rdata_q;
    logic [DATA_WIDTH-1:0] p1_rsp_rdata_d;
    logic [15:0]           conflict_cnt_q;
    logic [15:0]           conflict_cnt_d;

    arb_rr2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (p0_valid),
        .req1 (p1_valid),
        .lock (p1_lock),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // Memory request mux; everything is zero when no port holds the grant.
    // Write enable is suppressed during reset even though grants still follow valid.
    always_comb begin
        mem_wr_en = 1'b0;
        mem_addr  = {ADDRESS_WIDTH{1'b0}};
        mem_wd    = {DATA_WIDTH{1'b0}};
        if (gnt0) begin
            mem_wr_en = p0_we & ~rst;
            mem_addr  = p0_addr;
            mem_wd    = p0_wdata;
        end else if (gnt1) begin
            mem_wr_en = p1_we & ~rst;
            mem_addr  = p1_addr;
            mem_wd    = p1_wdata;
        end else begin
            mem_wr_en = 1'b0;
            mem_addr  = {ADDRESS_WIDTH{1'b0}};
            mem_wd    = {DATA_WIDTH{1'b0}};
        end
    end

    // Read capture at the accepting edge; data holds between responses.
    always_comb begin
        p0_rsp_valid_d = gnt0 & ~p0_we;
        p1_rsp_valid_d = gnt1 & ~p1_we;
        p0_rsp_rdata_d = p0_rsp_rdata_q;
        p1_rsp_rdata_d = p1_rsp_rdata_q;
        if (p0_rsp_valid_d) begin
            p0_rsp_rdata_d = mem_rd;
        end else begin
            p0_rsp_rdata_d = p0_rsp_rdata_q;
        end
        if (p1_rsp_valid_d) begin
            p1_rsp_rdata_d = mem_rd;
        end else begin
            p1_rsp_rdata_d = p1_rsp_rdata_q;
        end
    end

    // Every cycle with both ports requesting denies exactly one of them.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (p0_valid && p1_valid) begin
            conflict_cnt_d = sat_inc16(conflict_cnt_q);
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // Response and statistics registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rsp_valid_q <= 1'b0;
            p0_rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            p1_rsp_valid_q <= 1'b0;
            p1_rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            conflict_cnt_q <= 16'h0000;
        end else begin
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p0_rsp_rdata_q <= p0_rsp_rdata_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            p1_rsp_rdata_q <= p1_rsp_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign p0_rsp_valid = p0_rsp_valid_q;
    assign p0_rsp_rdata = p0_rsp_rdata_q;
    assign p1_rsp_valid = p1_rsp_valid_q;
    assign p1_rsp_rdata = p1_rsp_rdata_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed stimulus with a response scoreboard: read requests that the bench
// expects to be accepted push their expected data, and a monitor on the
// falling edge pops and compares whenever a response is presented.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_valid, p0_ready, p0_we;
    logic [31:0] p0_addr, p0_wdata;
    logic        p1_valid, p1_ready, p1_we;
    logic [31:0] p1_addr, p1_wdata;
    logic        p1_lock;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [15:0] conflict_cnt;

    logic [31:0] mem [0:255];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          n_checks;
    int          n_fail;

    dmem_arbiter #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .MAX_BURST     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_valid     (p0_valid),
        .p0_ready     (p0_ready),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_lock      (p1_lock),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_rdata (p1_rsp_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write at the rising edge.
    assign mem_rd = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wd;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (p0_rsp_valid) begin
                if (q0.size() == 0) chk("p0_unexpected_rsp", {31'd0, p0_rsp_valid}, 32'd0);
                else chk("p0_rsp_rdata", p0_rsp_rdata, q0.pop_front());
            end
            if (p1_rsp_valid) begin
                if (q1.size() == 0) chk("p1_unexpected_rsp", {31'd0, p1_rsp_valid}, 32'd0);
                else chk("p1_rsp_rdata", p1_rsp_rdata, q1.pop_front());
            end
        end
    end

    // One cycle of stimulus, starting and ending at a falling edge.
    task automatic cyc(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk, input logic eg0, input logic eg1,
                       input logic [31:0] er0, input logic [31:0] er1, input string nm);
        logic [31:0] ea;
        logic [31:0] ed;
        p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
        p1_lock  = lk;
        #1;
        ea = eg0 ? a0 : (eg1 ? a1 : 32'd0);
        ed = eg0 ? d0 : (eg1 ? d1 : 32'd0);
        chk({nm, "_p0_ready"}, {31'd0, p0_ready}, {31'd0, eg0});
        chk({nm, "_p1_ready"}, {31'd0, p1_ready}, {31'd0, eg1});
        chk({nm, "_mem_wr_en"}, {31'd0, mem_wr_en}, {31'd0, (eg0 & we0) | (eg1 & we1)});
        chk({nm, "_mem_addr"}, mem_addr, ea);
        chk({nm, "_mem_wd"}, mem_wd, ed);
        if (eg0 && !we0) q0.push_back(er0);
        if (eg1 && !we1) q1.push_back(er1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
            1'b0, 1'b0, 32'd0, 32'd0, "idle");
    endtask

    task automatic do_reset();
        p0_valid = 1'b0; p1_valid = 1'b0; p1_lock = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rst = 1'b1;
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;
        p1_lock  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state and grant-during-reset behaviour.
        chk("rst_p0_rsp_valid", {31'd0, p0_rsp_valid}, 32'd0);
        chk("rst_p1_rsp_valid", {31'd0, p1_rsp_valid}, 32'd0);
        chk("rst_p0_rsp_rdata", p0_rsp_rdata, 32'd0);
        chk("rst_p1_rsp_rdata", p1_rsp_rdata, 32'd0);
        chk("rst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'h1234;
        #1;
        chk("rst_p0_ready", {31'd0, p0_ready}, 32'd1);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        p0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Write then read back on the core port.
        cyc(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
            1'b1, 1'b0, 32'd0, 32'd0, "wr100");
        cyc(1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
            1'b1, 1'b0, 32'hDEADBEEF, 32'd0, "rd100");
        idle();
        chk("hold_p0_rsp_valid", {31'd0, p0_rsp_valid}, 32'd0);
        chk("hold_p0_rsp_rdata", p0_rsp_rdata, 32'hDEADBEEF);

        // Preload and alternate p0/p1 reads back to back.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 32'h20 + 32'(8 * i), 32'h11110000 + 32'(i), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
                1'b1, 1'b0, 32'd0, 32'd0, "pre0");
            cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h24 + 32'(8 * i), 32'h22220000 + 32'(i), 1'b0,
                1'b0, 1'b1, 32'd0, 32'd0, "pre1");
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 32'h20 + 32'(8 * i), 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
                1'b1, 1'b0, 32'h11110000 + 32'(i), 32'd0, "alt0");
            cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h24 + 32'(8 * i), 32'd0, 1'b0,
                1'b0, 1'b1, 32'd0, 32'h22220000 + 32'(i), "alt1");
        end
        idle();

        // Round-robin contention after reset: p0, p1, p0, p1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0,
                (i % 2) == 0, (i % 2) == 1, 32'hDEADBEEF, 32'h11110000, "rr");
        end
        idle();
        chk("rr_conflict_cnt", {16'd0, conflict_cnt}, 32'd4);

        // Lock burst: one RR p1 grant, 8 locked, then p0, then p1 resumes.
        do_reset();
        cyc(1'b1, 1'b1, 32'h300, 32'hA0, 1'b1, 1'b1, 32'h304, 32'hB0, 1'b0,
            1'b1, 1'b0, 32'd0, 32'd0, "lk_pre");
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 32'h300, 32'hA0, 1'b1, 1'b1, 32'h304, 32'hB0, 1'b1,
                i == 9, i != 9, 32'd0, 32'd0, "lk");
        end
        // Burst count saturates while p1 is alone; p0 then wins at once.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h304, 32'hB0, 1'b1,
                1'b0, 1'b1, 32'd0, 32'd0, "lk_sat");
        end
        cyc(1'b1, 1'b1, 32'h300, 32'hA0, 1'b1, 1'b1, 32'h304, 32'hB0, 1'b1,
            1'b1, 1'b0, 32'd0, 32'd0, "lk_after_sat");
        idle();

        // Reset right after an accepted read drops the response.
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h100;
        p1_valid = 1'b0; p1_lock = 1'b0;
        #1;
        chk("rstrd_p0_ready", {31'd0, p0_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        p0_valid = 1'b0;
        #1;
        chk("rstrd_rsp_valid", {31'd0, p0_rsp_valid}, 32'd0);
        chk("rstrd_rsp_rdata", p0_rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("rstrd_no_pulse", {31'd0, p0_rsp_valid}, 32'd0);
        end

        // Long contention saturates the conflict counter.
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h3F0; p0_wdata = 32'd0;
        p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h3F4; p1_wdata = 32'd0;
        repeat (65600) @(posedge clk);
        @(negedge clk);
        chk("conflict_sat", {16'd0, conflict_cnt}, 32'h0000FFFF);
        idle();
        idle();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
